// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   On-chip truth-table check for the two-input gate library. Drives the
//   shared a/b gate inputs through 00, 01, 10, 11, holds each vector for
//   SETTLE cycles, then compares the seven observed gate outputs against the
//   ideal values. It reports pass/fail, the failing-vector count, the sticky
//   failing-bit mask and the first failing vector.
//
// Parameters
//   SETTLE            cycles each vector is held before its compare edge (1..15)
// Ports
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   start             sweep request, honoured only in IDLE
//   gate_obs[6:0]     observed outputs {xnor, xor, nor, nand, ~a, or, and}
//   a, b              registered gate inputs
//   busy              sweep in progress
//   done              one-cycle end-of-sweep pulse
//   pass              last completed sweep had no failing vector
//   err_count[2:0]    failing vectors in the last sweep (0..4)
//   err_mask[6:0]     sticky OR of per-vector output mismatches
//   first_fail_vec    index of the first failing vector
//   first_fail_valid  first_fail_vec is meaningful

// Per-output reference gate and comparator. GATE selects which library
// output this lane checks; diff is 1 when the observed bit disagrees.
module gsc_bit_cmp #(
  parameter int GATE = 0
) (
  input  logic a,
  input  logic b,
  input  logic obs,
  output logic diff
);

  logic ref_bit;

  always_comb begin
    ref_bit = 1'b0;
    case (GATE)
      0:       ref_bit = a & b;
      1:       ref_bit = a | b;
      2:       ref_bit = ~a;
      3:       ref_bit = ~(a & b);
      4:       ref_bit = ~(a | b);
      5:       ref_bit = a ^ b;
      6:       ref_bit = ~(a ^ b);
      default: ref_bit = 1'b0;
    endcase
  end

  assign diff = obs ^ ref_bit;

endmodule

module gate_sweep_checker #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] gate_obs,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [6:0] err_mask,
  output logic [1:0] first_fail_vec,
  output logic       first_fail_valid
);

  localparam int       NUM_GATES = 7;
  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t     state;
  logic [1:0] vec;
  logic [3:0] cnt;

  logic [NUM_GATES-1:0] diff;
  logic                 hit;
  logic [2:0]           ec_nxt;

  // The reference is computed from the registered a/b the gates actually
  // see, so the compare tracks exactly what was driven.
  for (genvar g = 0; g < NUM_GATES; g++) begin : g_cmp
    gsc_bit_cmp #(.GATE(g)) u_cmp (
      .a    (a),
      .b    (b),
      .obs  (gate_obs[g]),
      .diff (diff[g])
    );
  end

  assign hit    = |diff;
  // Count including the vector being compared this edge; pass on the last
  // vector must see its own result.
  assign ec_nxt = err_count + 3'(hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      vec              <= 2'd0;
      cnt              <= 4'd0;
      a                <= 1'b0;
      b                <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 3'd0;
      err_mask         <= 7'd0;
      first_fail_vec   <= 2'd0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            vec              <= 2'd0;
            a                <= 1'b0;
            b                <= 1'b0;
            cnt              <= SETTLE_L;
            pass             <= 1'b0;
            err_count        <= 3'd0;
            err_mask         <= 7'd0;
            first_fail_vec   <= 2'd0;
            first_fail_valid <= 1'b0;
            busy             <= 1'b1;
            state            <= RUN;
          end
        end

        RUN: begin
          cnt <= cnt - 4'd1;
          // cnt == 1 marks the last cycle of the hold: compare edge.
          if (cnt == 4'd1) begin
            if (hit) begin
              err_count <= ec_nxt;
              err_mask  <= err_mask | diff;
              if (!first_fail_valid) begin
                first_fail_vec   <= vec;
                first_fail_valid <= 1'b1;
              end
            end
            if (vec != 2'd3) begin
              vec    <= vec + 2'd1;
              {a, b} <= vec + 2'd1;
              cnt    <= SETTLE_L;
            end else begin
              vec   <= 2'd0;
              a     <= 1'b0;
              b     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (ec_nxt == 3'd0);
              state <= FIN;
            end
          end
        end

        // Single cycle; start is not looked at here, so a held start
        // re-arms on the following IDLE edge.
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking stimulus/response stage for the basic two-input gate library. It drives the shared `a`/`b` inputs of the gate set through all four input combinations, samples the seven gate outputs after a programmable settle time, and compares each sample against the ideal truth table. It reports pass/fail, the number of failing vectors, the failing output bits, and the first failing vector. It sits both directly upstream of the gates (it feeds them) and directly downstream (it consumes their outputs), and replaces hand-written truth-table printing with a synthesizable, on-chip check.

## Interface
- `SETTLE`, default 2: cycles each vector is held before its outputs are compared; legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a sweep; sampled only in IDLE.
- `gate_obs` in 7: observed gate outputs.
  - [0] and, [1] or, [2] not(a), [3] nand, [4] nor, [5] xor, [6] xnor.
- `a` out 1: gate input A, registered.
- `b` out 1: gate input B, registered.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `pass` out 1: 1 when the last completed sweep had zero failing vectors.
- `err_count` out 3: number of failing vectors in the last sweep, 0..4.
- `err_mask` out 7: sticky OR of (`gate_obs` ^ expected) over all vectors of the sweep.
- `first_fail_vec` out 2: index of the first failing vector.
- `first_fail_valid` out 1: `first_fail_vec` is meaningful.

## Operation
- States: IDLE, RUN, FIN.
- Vector index `vec` is 2 bits, values 0..3, applied as `a` = vec[1], `b` = vec[0]. The sweep order is therefore 00, 01, 10, 11.
- Expected value per vector: {xnor, xor, nor, nand, ~a, or, and} of the applied `a`/`b`.
- IDLE, on an edge with `start` = 1:
  - Set `vec` = 0 and `a`/`b` = 00.
  - Load the settle counter with SETTLE.
  - Clear `err_count`, `err_mask`, `first_fail_*` and `pass`.
  - Set `busy` = 1 and go to RUN.
- RUN:
  - The settle counter decrements every edge.
  - On the edge where the counter equals 1 (the compare edge):
    - Compare `gate_obs` with the expected value for the current `vec`.
    - If any bit differs: increment `err_count` and OR the difference into `err_mask`.
    - If `first_fail_valid` = 0, load `first_fail_vec` = vec and set `first_fail_valid` = 1.
  - On that compare edge, if `vec` < 3: increment `vec`, drive the new `a`/`b`, and reload the counter with SETTLE.
  - If `vec` = 3: go to FIN with `done` = 1, `busy` = 0, `pass` = (final err_count == 0), and `a`/`b` returned to 00.
  - `start` is ignored throughout RUN.
- FIN: lasts exactly one cycle. `done` drops on the next edge and the state returns to IDLE. `start` is ignored during FIN.
- Result outputs hold their values from FIN until the next accepted `start`.
- A `start` held high retriggers on the first IDLE edge after FIN. This gives back-to-back sweeps separated by one FIN cycle and one IDLE cycle.
- Reset mid-sweep: all state and outputs return to their reset values immediately, with no `done` pulse.

## Timing
- Reset values: `a` = 0, `b` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `err_mask` = 0, `first_fail_vec` = 0, `first_fail_valid` = 0; state IDLE.
- Let E0 be the edge that accepts `start`.
- Vector k is driven from edge E0 + k·SETTLE. Its compare edge is E0 + (k+1)·SETTLE.
- `gate_obs` must be stable by each compare edge. Gate paths are combinational, so any SETTLE ≥ 1 is valid.
- `done` is high for the cycle following edge E0 + 4·SETTLE. `busy` is high from E0 until that same edge.
- All results are valid in the `done` cycle.
- Total sweep latency is 4·SETTLE cycles.

## Test plan
- Correct gates, SETTLE = 2, single `start` pulse:
  - `a`/`b` = 00, 01, 10, 11, each held 2 cycles.
  - `done` pulses 8 cycles after the start edge.
  - `pass` = 1, `err_count` = 0, `err_mask` = 0, `first_fail_valid` = 0.
- `and` output stuck at 0:
  - Only vector 3 fails.
  - `err_count` = 1, `err_mask` = 7'b0000001, `first_fail_vec` = 3, `first_fail_valid` = 1, `pass` = 0.
- `xor` output inverted:
  - All vectors fail.
  - `err_count` = 4, `err_mask` = 7'b0100000, `first_fail_vec` = 0, `pass` = 0.
- `start` pulsed during RUN:
  - Ignored; the sweep and timing are unchanged.
- `start` held high:
  - The second sweep begins 2 cycles after `done` rises.
  - Results are cleared at the second accept edge and the second run reports independently.
- SETTLE = 1 and SETTLE = 15:
  - `done` arrives 4 and 60 cycles after the start edge respectively.
- `rst` asserted while `vec` = 2:
  - Outputs go to reset values asynchronously, with no `done` pulse.
  - A following `start` completes a full, correct sweep.
